hist_calc: RTL and testbench



---
 rtl/hist_pkg.sv | 21 ++
 rtl/hist_calc_if.sv | 24 ++
 rtl/hist_ram.sv | 28 ++
 rtl/hist_calc.sv | 179 +++++++++++++++++
 tb/tb_hist_calc.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hist_pkg.sv
// Shared constants and state encoding for the luma histogram engine.
package hist_pkg;

    localparam int NUM_BINS = 256;

    // Luma weights sum to 256, so the weighted sum shifted right by 8 stays in pixel range.
    localparam int LUMA_R = 77;
    localparam int LUMA_G = 150;
    localparam int LUMA_B = 29;

    typedef enum logic [2:0] {
        CLEAR,
        WAIT_FRAME,
        ACCUM,
        DRAIN,
        DUMP_RD,
        DUMP_ACK,
        DUMP_REL
    } hist_state_e;

endpackage

// File: rtl/hist_calc_if.sv
// Pixel input and histogram-bin handshake bundle; master drives pixels and acknowledges bins.
interface hist_calc_if #(
    parameter int PIX_W = 8,
    parameter int BIN_W = 16
);
    logic             dv;
    logic             vs;
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
    logic [BIN_W-1:0] hist_bin_data;
    logic             hist_bin_ready;
    logic             hist_bin_saved;

    modport master (
        output dv, vs, r, g, b, hist_bin_saved,
        input  hist_bin_data, hist_bin_ready
    );

    modport slave (
        input  dv, vs, r, g, b, hist_bin_saved,
        output hist_bin_data, hist_bin_ready
    );
endinterface

// File: rtl/hist_ram.sv
// Simple dual-port bin memory: one write port, one registered read port (read-first).
// Read data appears one cycle after the address; no backpressure.
module hist_ram
    import hist_pkg::*;
#(
    parameter int DEPTH = NUM_BINS,
    parameter int DW    = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rd_q <= mem_q[raddr_i];
    end

    assign rdata_o = rd_q;
endmodule

// File: rtl/hist_calc.sv
// Per-frame 256-bin luma histogram: 3-stage accumulate pipeline, then dumps bins over a 4-phase handshake.
// First bin offered 5 cycles after vs rise is sampled; the dump stalls indefinitely on hist_bin_saved.
module hist_calc
    import hist_pkg::*;
#(
    parameter int BIN_W = 16,
    parameter int PIX_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    hist_calc_if.slave pix,
    output logic       hist_busy,
    output logic       frame_skipped
);
    localparam int SUM_W = PIX_W + 8;

    hist_state_e      state_q, state_d;
    logic [PIX_W-1:0] idx_q, idx_d;
    logic [1:0]       drain_q, drain_d;
    logic             vs_d1_q, vs_d2_q;
    logic             vs_rise, vs_fall;

    logic             s1_vld_q, s1_vld_d;
    logic [PIX_W-1:0] s1_y_q;
    logic             s2_vld_q;
    logic [PIX_W-1:0] s2_y_q;

    logic             fwd_vld_q;
    logic [PIX_W-1:0] fwd_addr_q;
    logic [BIN_W-1:0] fwd_dat_q;

    logic [BIN_W-1:0] dat_q, dat_d;
    logic             rdy_q, rdy_d;
    logic             skip_q, skip_d;

    logic [SUM_W-1:0] luma_sum;
    logic [PIX_W-1:0] luma_y;
    logic [BIN_W-1:0] cur_cnt, inc_cnt;

    logic             wr_en;
    logic [PIX_W-1:0] wr_addr;
    logic [BIN_W-1:0] wr_dat;
    logic [PIX_W-1:0] rd_addr;
    logic [BIN_W-1:0] rd_dat;

    assign luma_sum = SUM_W'(LUMA_R) * SUM_W'(pix.r)
                    + SUM_W'(LUMA_G) * SUM_W'(pix.g)
                    + SUM_W'(LUMA_B) * SUM_W'(pix.b);
    assign luma_y   = luma_sum[SUM_W-1:8];

    assign vs_rise  = vs_d1_q & ~vs_d2_q;
    assign vs_fall  = ~vs_d1_q & vs_d2_q;
    assign s1_vld_d = (state_q == ACCUM) & pix.dv & ~pix.vs;

    // The RAM reads first on a same-address collision, so the last write is replayed here.
    assign cur_cnt = (fwd_vld_q && (fwd_addr_q == s2_y_q)) ? fwd_dat_q : rd_dat;
    assign inc_cnt = (&cur_cnt) ? cur_cnt : cur_cnt + BIN_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        dat_d   = dat_q;
        rdy_d   = rdy_q;
        wr_en   = s2_vld_q;
        wr_addr = s2_y_q;
        wr_dat  = inc_cnt;

        case (state_q)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_dat  = '0;
                idx_d   = idx_q + PIX_W'(1);
                if (&idx_q) begin
                    state_d = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (vs_fall) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (vs_rise) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd2) begin
                    state_d = DUMP_RD;
                    idx_d   = '0;
                    drain_d = '0;
                end
            end
            DUMP_RD: begin
                dat_d   = rd_dat;
                rdy_d   = 1'b1;
                state_d = DUMP_ACK;
            end
            DUMP_ACK: begin
                if (pix.hist_bin_saved) begin
                    rdy_d   = 1'b0;
                    wr_en   = 1'b1;
                    wr_addr = idx_q;
                    wr_dat  = '0;
                    state_d = DUMP_REL;
                end
            end
            DUMP_REL: begin
                if (!pix.hist_bin_saved) begin
                    idx_d   = idx_q + PIX_W'(1);
                    state_d = (&idx_q) ? WAIT_FRAME : DUMP_RD;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // The dump read is issued on entry to DUMP_RD so the bin is ready to latch on its way out.
    assign rd_addr = (state_d == DUMP_RD) ? idx_d : s1_y_q;

    assign skip_d = vs_fall && !(state_q inside {WAIT_FRAME, ACCUM});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            idx_q      <= '0;
            drain_q    <= '0;
            vs_d1_q    <= 1'b0;
            vs_d2_q    <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_y_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_y_q     <= '0;
            fwd_vld_q  <= 1'b0;
            fwd_addr_q <= '0;
            fwd_dat_q  <= '0;
            dat_q      <= '0;
            rdy_q      <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            drain_q    <= drain_d;
            vs_d1_q    <= pix.vs;
            vs_d2_q    <= vs_d1_q;
            s1_vld_q   <= s1_vld_d;
            s1_y_q     <= luma_y;
            s2_vld_q   <= s1_vld_q;
            s2_y_q     <= s1_y_q;
            fwd_vld_q  <= wr_en;
            fwd_addr_q <= wr_addr;
            fwd_dat_q  <= wr_dat;
            dat_q      <= dat_d;
            rdy_q      <= rdy_d;
            skip_q     <= skip_d;
        end
    end

    hist_ram #(
        .DEPTH (2 ** PIX_W),
        .DW    (BIN_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_dat),
        .raddr_i (rd_addr),
        .rdata_o (rd_dat)
    );

    assign pix.hist_bin_data  = dat_q;
    assign pix.hist_bin_ready = rdy_q;
    assign hist_busy          = !(state_q inside {WAIT_FRAME, ACCUM});
    assign frame_skipped      = skip_q;
endmodule

// File: tb/tb_hist_calc.sv
// Directed-vector bench for hist_calc with hand-computed bin contents.
module tb_hist_calc;
    import hist_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic hist_busy;
    logic frame_skipped;

    hist_calc_if #(.PIX_W(8), .BIN_W(16)) hif ();

    hist_calc #(.BIN_W(16), .PIX_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .pix           (hif),
        .hist_busy     (hist_busy),
        .frame_skipped (frame_skipped)
    );

    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_err    = 0;
    int skip_cnt = 0;
    logic [15:0] got   [256];
    logic [15:0] exp_b [256];

    always @(negedge clk) begin
        if (frame_skipped === 1'b1) skip_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv, input int n);
        hif.dv = 1'b1;
        hif.r  = rv;
        hif.g  = gv;
        hif.b  = bv;
        repeat (n) @(negedge clk);
        hif.dv = 1'b0;
    endtask

    task automatic start_frame();
        hif.vs = 1'b1;
        repeat (3) @(negedge clk);
        hif.vs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_exp();
        foreach (exp_b[i]) exp_b[i] = 16'h0;
    endtask

    task automatic dump(input int lo, input int hi, input bit alt);
        int bad;
        int n;
        int t;
        int d;
        logic [15:0] first;
        bad = 0;
        n   = 0;
        for (int i = lo; i < hi; i++) begin
            t = 0;
            while (hif.hist_bin_ready !== 1'b1 && t < 64) begin
                @(negedge clk);
                t++;
            end
            if (hif.hist_bin_ready !== 1'b1) begin
                chk("rdy_wait", {31'b0, hif.hist_bin_ready}, 32'd1);
                break;
            end
            first  = hif.hist_bin_data;
            got[i] = first;
            d = (alt && i[0]) ? 7 : 1;
            repeat (d) begin
                @(negedge clk);
                if (hif.hist_bin_ready !== 1'b1 || hif.hist_bin_data !== first) bad++;
            end
            hif.hist_bin_saved = 1'b1;
            @(negedge clk);
            if (hif.hist_bin_ready !== 1'b0) bad++;
            hif.hist_bin_saved = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("dump_stable", bad, 0);
        chk("dump_count", n, hi - lo);
    endtask

    task automatic check_bins(input string tag, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            chk($sformatf("%s_bin%0d", tag, i), {16'b0, got[i]}, {16'b0, exp_b[i]});
        end
    endtask

    initial begin
        int busy_cnt;
        hif.dv = 1'b0;
        hif.vs = 1'b0;
        hif.r  = '0;
        hif.g  = '0;
        hif.b  = '0;
        hif.hist_bin_saved = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rdy",  {31'b0, hif.hist_bin_ready}, 32'd0);
        chk("rst_data", {16'b0, hif.hist_bin_data}, 32'd0);
        chk("rst_busy", {31'b0, hist_busy}, 32'd1);
        chk("rst_skip", {31'b0, frame_skipped}, 32'd0);
        rst = 1'b0;

        // Clear phase; pixels offered in WAIT_FRAME must be ignored.
        busy_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            if (hist_busy) busy_cnt++;
            if (k == 260) begin
                hif.dv = 1'b1;
                hif.r  = 8'd50;
                hif.g  = 8'd50;
                hif.b  = 8'd50;
            end
            @(negedge clk);
        end
        hif.dv = 1'b0;
        chk("clear_busy_cycles", busy_cnt, 256);
        chk("idle_after_clear", {31'b0, hist_busy}, 32'd0);

        // Empty frame.
        start_frame();
        hif.vs = 1'b1;
        dump(0, 256, 1'b0);
        clear_exp();
        check_bins("empty", 0, 256);

        // 100 mid-grey pixels, with first-ready latency.
        start_frame();
        chk("busy_accum", {31'b0, hist_busy}, 32'd0);
        send(8'd128, 8'd128, 8'd128, 100);
        hif.vs = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 5) chk("rdy_lat_5", {31'b0, hif.hist_bin_ready}, 32'd0);
            if (k == 6) chk("rdy_lat_6", {31'b0, hif.hist_bin_ready}, 32'd1);
        end
        chk("busy_dump", {31'b0, hist_busy}, 32'd1);
        dump(0, 256, 1'b0);
        clear_exp();
        exp_b[128] = 16'd100;
        check_bins("grey", 0, 256);

        // Same-bin and A,B,A sequences, pure primaries, and dv held during vs high.
        start_frame();
        repeat (50) begin
            send(8'd10, 8'd10, 8'd10, 2);
            send(8'd20, 8'd20, 8'd20, 1);
            send(8'd10, 8'd10, 8'd10, 1);
        end
        send(8'd255, 8'd0,   8'd0,   1);
        send(8'd0,   8'd255, 8'd0,   1);
        send(8'd0,   8'd0,   8'd255, 1);
        send(8'd255, 8'd255, 8'd255, 1);
        hif.vs = 1'b1;
        hif.dv = 1'b1;
        hif.r  = 8'd10;
        hif.g  = 8'd10;
        hif.b  = 8'd10;
        dump(0, 256, 1'b0);
        hif.dv = 1'b0;
        clear_exp();
        exp_b[10]  = 16'd150;
        exp_b[20]  = 16'd50;
        exp_b[76]  = 16'd1;
        exp_b[149] = 16'd1;
        exp_b[28]  = 16'd1;
        exp_b[255] = 16'd1;
        check_bins("fwd", 0, 256);

        // Saturation, with alternating slow/fast acknowledge.
        start_frame();
        send(8'd0, 8'd0, 8'd0, 70000);
        hif.vs = 1'b1;
        dump(0, 256, 1'b1);
        clear_exp();
        exp_b[0] = 16'hFFFF;
        check_bins("sat", 0, 256);

        // Next frame counts from a cleared histogram.
        start_frame();
        send(8'd0, 8'd0, 8'd0, 3);
        hif.vs = 1'b1;
        dump(0, 256, 1'b0);
        clear_exp();
        exp_b[0] = 16'd3;
        check_bins("after_sat", 0, 256);
        chk("skip_none", skip_cnt, 0);

        // Frame start during the dump is skipped.
        start_frame();
        send(8'd128, 8'd128, 8'd128, 5);
        hif.vs = 1'b1;
        dump(0, 3, 1'b0);
        hif.vs = 1'b0;
        send(8'd60, 8'd60, 8'd60, 10);
        dump(3, 256, 1'b0);
        clear_exp();
        exp_b[128] = 16'd5;
        check_bins("skipdump", 0, 256);
        chk("skip_pulses", skip_cnt, 1);

        // Partial dump abandoned by reset at index 100.
        start_frame();
        send(8'd10, 8'd10, 8'd10, 3);
        hif.vs = 1'b1;
        dump(0, 100, 1'b0);
        clear_exp();
        exp_b[10] = 16'd3;
        check_bins("partial", 0, 100);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rdy",  {31'b0, hif.hist_bin_ready}, 32'd0);
        chk("midrst_busy", {31'b0, hist_busy}, 32'd1);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("midrst_idle", {31'b0, hist_busy}, 32'd0);

        start_frame();
        send(8'd30, 8'd30, 8'd30, 2);
        hif.vs = 1'b1;
        dump(0, 256, 1'b0);
        clear_exp();
        exp_b[30] = 16'd2;
        check_bins("post_rst", 0, 256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
